// File: rtl/signed_mult8_pkg.sv
// Shared types and widths for the signed_mult8 scheduler slice.
package signed_mult8_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 16;
  localparam int ID_W  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_DONE
  } state_t;

  // Full-width two's complement product of two 8-bit operands.
  function automatic logic [RES_W-1:0] mult_s(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    return $signed({{OP_W{a[OP_W-1]}}, a}) * $signed({{OP_W{b[OP_W-1]}}, b});
  endfunction

endpackage

// File: rtl/signed_mult8_sched_rr_arb2.sv
// Two-way round-robin arbiter; priority flips to the other requester after each accepted grant.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic prio1;

  assign gnt0 = en & req0 & (~req1 | ~prio1);
  assign gnt1 = en & req1 & (~req0 | prio1);

  always_ff @(posedge clk) begin
    if (rst)
      prio1 <= 1'b0;
    else if (gnt0 | gnt1)
      prio1 <= gnt0;
  end

endmodule

// File: rtl/signed_mult8_sched.sv
// Round-robin scheduler feeding one shared signed_mult8 over the ABin/ABSel bus.
// Optional self-check (chk_err/chk_cnt) is built when SIGNED_MULT8_SCHED_CHECK_EN is defined.
module signed_mult8_sched
  import signed_mult8_pkg::*;
#(
  parameter int MULT_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_res,
  input  logic        rsp_ready,
  output logic [7:0]  m_abin,
  output logic        m_absel,
  input  logic [15:0] m_res
`ifdef SIGNED_MULT8_SCHED_CHECK_EN
  ,
  output logic        chk_err,
  output logic [7:0]  chk_cnt
`endif
);

  localparam logic [3:0] LAST_CNT = 4'(MULT_LATENCY - 1);

  state_t           state, next_state;
  logic             gnt0, gnt1, accept;
  logic [OP_W-1:0]  a_q, b_q, abin_q;
  logic [ID_W-1:0]  id_q;
  logic             absel_q;
  logic [3:0]       cnt;
  logic [RES_W-1:0] res_q;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (state == S_IDLE),
    .req0 (req0_valid),
    .req1 (req1_valid),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign accept     = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = (state == S_DONE);
  assign rsp_id     = id_q;
  assign rsp_res    = res_q;
  assign m_abin     = abin_q;
  assign m_absel    = absel_q;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (accept) next_state = S_LOAD_A;
      S_LOAD_A: next_state = S_LOAD_B;
      S_LOAD_B: next_state = S_WAIT;
      S_WAIT:   if (cnt == LAST_CNT) next_state = S_DONE;
      S_DONE:   if (rsp_ready) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Bus registers are loaded one edge ahead so LOAD_A/LOAD_B present A/B for their whole cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      abin_q  <= '0;
      absel_q <= 1'b0;
      cnt     <= '0;
      res_q   <= '0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q     <= gnt1 ? req1_a : req0_a;
            b_q     <= gnt1 ? req1_b : req0_b;
            id_q    <= gnt1;
            abin_q  <= gnt1 ? req1_a : req0_a;
            absel_q <= 1'b0;
            cnt     <= '0;
          end
        end
        S_LOAD_A: begin
          abin_q  <= b_q;
          absel_q <= 1'b1;
        end
        S_WAIT: begin
          if (cnt == LAST_CNT) begin
            res_q <= m_res;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SIGNED_MULT8_SCHED_CHECK_EN
  logic done_entry;

  // The captured product is compared once, in the first DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_entry <= 1'b0;
      chk_err    <= 1'b0;
      chk_cnt    <= '0;
    end else begin
      done_entry <= (state == S_WAIT) && (next_state == S_DONE);
      if (done_entry && (res_q != mult_s(a_q, b_q))) begin
        chk_err <= 1'b1;
        if (chk_cnt != 8'hFF)
          chk_cnt <= chk_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_signed_mult8_sched.sv
// Randomised and directed bench for signed_mult8_sched with a behavioural multiplier stand-in and scoreboard.
// Define SIGNED_MULT8_SCHED_CHECK_EN to also exercise the chk_* ports with an injected multiplier fault.
module tb_signed_mult8_sched;

  localparam int MULT_LATENCY = 2;

  logic        clk_dut = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [15:0] rsp_res;
  logic [7:0]  m_abin;
  logic        m_absel;
  logic [15:0] m_res;
  logic        inject_fault = 1'b0;
`ifdef SIGNED_MULT8_SCHED_CHECK_EN
  logic        chk_err;
  logic [7:0]  chk_cnt;
`endif

  always #5 clk_dut = ~clk_dut;

  signed_mult8_sched #(.MULT_LATENCY(MULT_LATENCY)) dut (
    .clk        (clk_dut),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_res    (rsp_res),
    .rsp_ready  (rsp_ready),
    .m_abin     (m_abin),
    .m_absel    (m_absel),
    .m_res      (m_res)
`ifdef SIGNED_MULT8_SCHED_CHECK_EN
    ,
    .chk_err    (chk_err),
    .chk_cnt    (chk_cnt)
`endif
  );

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 16'(sa * sb);
  endfunction

  // Multiplier stand-in: A loads while ABSel=0; product appears MULT_LATENCY cycles after the B-load cycle.
  logic [7:0]  mul_a;
  logic [15:0] mul_pipe [MULT_LATENCY];
  always @(posedge clk_dut) begin
    if (!m_absel) mul_a <= m_abin;
    mul_pipe[0] <= m_absel ? ref_prod(mul_a, m_abin) : 16'hDEAD;
    for (int i = 1; i < MULT_LATENCY; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign m_res = mul_pipe[MULT_LATENCY-1] ^ {15'd0, inject_fault};

  typedef struct {
    logic        id;
    logic [15:0] res;
    int          acc_cyc;
  } exp_t;

  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  int          rsp_ready_pct = 100;
  exp_t        exp_q[$];
  logic [15:0] op_q0[$], op_q1[$];
  logic        grant_log[$];
  logic        prefer1 = 1'b0;
  logic        busy    = 1'b0;
  logic        rsp_seen = 1'b0;
  logic [15:0] last_res = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    req0_valid = (op_q0.size() > 0);
    req1_valid = (op_q1.size() > 0);
    if (req0_valid) {req0_a, req0_b} = op_q0[0];
    else            {req0_a, req0_b} = 16'($urandom);
    if (req1_valid) {req1_a, req1_b} = op_q1[0];
    else            {req1_a, req1_b} = 16'($urandom);
    rsp_ready = ($urandom_range(99) < rsp_ready_pct);
  endtask

  // One negedge-aligned cycle per iteration: drive, compare against the model, then advance.
  task automatic runCycles(input int n);
    logic exp0, exp1;
    for (int k = 0; k < n; k++) begin
      applyStimulus();
      #1;
      exp0 = !busy && req0_valid && (!req1_valid || !prefer1);
      exp1 = !busy && req1_valid && (!req0_valid || prefer1);
      checkOutput("req0_ready", 32'(req0_ready), 32'(exp0));
      checkOutput("req1_ready", 32'(req1_ready), 32'(exp1));
      if (req0_ready && req0_valid) grant_log.push_back(1'b0);
      if (req1_ready && req1_valid) grant_log.push_back(1'b1);
      if (exp_q.size() == 0) begin
        checkOutput("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      end else if (rsp_valid) begin
        if (!rsp_seen) begin
          checkOutput("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(2 + MULT_LATENCY));
          rsp_seen = 1'b1;
        end
        checkOutput("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
        checkOutput("rsp_res", 32'(rsp_res), 32'(exp_q[0].res));
        if (rsp_ready) begin
          last_res = exp_q[0].res;
          void'(exp_q.pop_front());
          busy     = 1'b0;
          rsp_seen = 1'b0;
        end
      end
      if (exp0 || exp1) begin
        exp_t e;
        e.id      = exp1;
        e.res     = (exp1 ? ref_prod(req1_a, req1_b) : ref_prod(req0_a, req0_b)) ^ {15'd0, inject_fault};
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        if (exp1) void'(op_q1.pop_front());
        else      void'(op_q0.pop_front());
        busy    = 1'b1;
        prefer1 = exp0;
      end
      @(negedge clk_dut);
      cyc++;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    op_q0.delete();
    op_q1.delete();
    applyStimulus();
    @(negedge clk_dut);
    @(negedge clk_dut);
    cyc += 2;
    exp_q.delete();
    busy     = 1'b0;
    rsp_seen = 1'b0;
    prefer1  = 1'b0;
    rst      = 1'b0;
  endtask

  initial begin
    $display("[TB] start, MULT_LATENCY=%0d", MULT_LATENCY);
    rsp_ready_pct = 100;
    doReset();
    #1;
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_rsp_res", 32'(rsp_res), 32'd0);
    checkOutput("rst_m_abin", 32'(m_abin), 32'd0);
    checkOutput("rst_m_absel", 32'(m_absel), 32'd0);
    @(negedge clk_dut);
    cyc++;

    // Single request: bus sequence A then B, product 3 * -5.
    op_q0.push_back({8'h03, 8'hFB});
    runCycles(1);
    #1;
    checkOutput("t1_absel_a", 32'(m_absel), 32'd0);
    checkOutput("t1_abin_a", 32'(m_abin), 32'h03);
    @(negedge clk_dut);
    cyc++;
    runCycles(1);
    #1;
    checkOutput("t1_absel_b", 32'(m_absel), 32'd1);
    checkOutput("t1_abin_b", 32'(m_abin), 32'hFB);
    @(negedge clk_dut);
    cyc++;
    runCycles(MULT_LATENCY + 6);
    checkOutput("t1_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t1_res", 32'(last_res), 32'hFFF1);

    // Both requesters continuously valid: grants alternate starting at req0.
    doReset();
    grant_log.delete();
    op_q0.push_back({8'h80, 8'h80});
    op_q1.push_back({8'h7F, 8'h80});
    for (int i = 0; i < 2; i++) begin
      op_q0.push_back(16'($urandom));
      op_q1.push_back(16'($urandom));
    end
    runCycles(6 * (4 + MULT_LATENCY) + 10);
    checkOutput("t2_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t2_grants", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < grant_log.size(); i++)
      checkOutput("t2_grant_order", 32'(grant_log[i]), 32'(i % 2));

    // Backpressure: response held for well over 10 cycles, requester kept waiting.
    rsp_ready_pct = 0;
    op_q0.push_back(16'($urandom));
    op_q0.push_back(16'($urandom));
    runCycles(MULT_LATENCY + 16);
    checkOutput("t3_stalled", 32'(exp_q.size()), 32'd1);
    rsp_ready_pct = 100;
    runCycles(2 * (4 + MULT_LATENCY) + 6);
    checkOutput("t3_drained", 32'(exp_q.size()), 32'd0);

    // Reset in WAIT discards the in-flight op; afterwards req0 has priority again.
    op_q1.push_back({8'h55, 8'h33});
    runCycles(3);
    rst = 1'b1;
    op_q0.delete();
    op_q1.delete();
    applyStimulus();
    @(negedge clk_dut);
    cyc++;
    #1;
    checkOutput("t4_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("t4_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("t4_rsp_res", 32'(rsp_res), 32'd0);
    checkOutput("t4_m_abin", 32'(m_abin), 32'd0);
    checkOutput("t4_m_absel", 32'(m_absel), 32'd0);
    exp_q.delete();
    busy     = 1'b0;
    rsp_seen = 1'b0;
    prefer1  = 1'b0;
    rst      = 1'b0;
    @(negedge clk_dut);
    cyc++;
    grant_log.delete();
    op_q0.push_back({8'h00, 8'h9C});
    op_q1.push_back({8'hFF, 8'hFF});
    runCycles(2 * (4 + MULT_LATENCY) + 6);
    checkOutput("t4_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t4_first_grant", 32'(grant_log[0]), 32'd0);
    checkOutput("t5_minus1_sq", 32'(last_res), 32'h0001);

    // Random traffic from both sides with random consumer stalls.
    rsp_ready_pct = 70;
    for (int i = 0; i < 20; i++) begin
      op_q0.push_back(16'($urandom));
      op_q1.push_back(16'($urandom));
    end
    runCycles(40 * (4 + MULT_LATENCY) * 2 + 40);
    checkOutput("t5_drained", 32'(exp_q.size()), 32'd0);

`ifdef SIGNED_MULT8_SCHED_CHECK_EN
    checkOutput("t6_err_clean", 32'(chk_err), 32'd0);
    checkOutput("t6_cnt_clean", 32'(chk_cnt), 32'd0);
    rsp_ready_pct = 100;
    inject_fault  = 1'b1;
    for (int i = 0; i < 3; i++) op_q0.push_back(16'($urandom));
    runCycles(3 * (4 + MULT_LATENCY) + 6);
    checkOutput("t6_err_set", 32'(chk_err), 32'd1);
    checkOutput("t6_cnt_3", 32'(chk_cnt), 32'd3);
    for (int i = 0; i < 260; i++) op_q0.push_back(16'($urandom));
    runCycles(260 * (4 + MULT_LATENCY) + 10);
    checkOutput("t6_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t6_cnt_sat", 32'(chk_cnt), 32'd255);
    checkOutput("t6_err_sticky", 32'(chk_err), 32'd1);
    inject_fault = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
